// File: rtl/master_memory_dp_bram.sv
// Dual-port local memory for master devices: byte-lane writes, 1/2-cycle
// read latency, out-of-range error responses and a same-address counter.
module master_memory_dp_bram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 4096,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_rvalid,
  output logic                    a_err,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_rvalid,
  output logic                    b_err,
  output logic [15:0]             coll_cnt
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int IW   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = MEM_SIZE[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic                  req    [2];
  logic                  we     [2];
  logic [ADDR_WIDTH-1:0] addr   [2];
  logic [BE_W-1:0]       be     [2];
  logic [DATA_WIDTH-1:0] wdata  [2];
  logic [DATA_WIDTH-1:0] rdata  [2];
  logic                  rvalid [2];
  logic                  err    [2];
  logic                  in_rng [2];
  logic                  wr     [2];
  logic                  rd     [2];
  logic [IW-1:0]         idx    [2];
  logic                  same;

  assign req[0]   = a_req;
  assign we[0]    = a_we;
  assign addr[0]  = a_addr;
  assign be[0]    = a_be;
  assign wdata[0] = a_wdata;
  assign req[1]   = b_req;
  assign we[1]    = b_we;
  assign addr[1]  = b_addr;
  assign be[1]    = b_be;
  assign wdata[1] = b_wdata;

  assign a_rdata  = rdata[0];
  assign a_rvalid = rvalid[0];
  assign a_err    = err[0];
  assign b_rdata  = rdata[1];
  assign b_rvalid = rvalid[1];
  assign b_err    = err[1];

  assign same = in_rng[0] & in_rng[1]
              & (addr[0] == addr[1]);

  // B lanes first so A overrides any byte both ports enable
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (wr[1] && be[1][i])
        mem[idx[1]][8*i +: 8] <= wdata[1][8*i +: 8];
      if (wr[0] && be[0][i])
        mem[idx[0]][8*i +: 8] <= wdata[0][8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      coll_cnt <= '0;
    end else if (req[0] && req[1] && same
                 && coll_cnt != 16'hFFFF) begin
      coll_cnt <= coll_cnt + 16'd1;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int O = 1 - p;

    logic                  v1;
    logic                  e1;
    logic [DATA_WIDTH-1:0] d1;
    logic                  vq;
    logic                  eq;
    logic [DATA_WIDTH-1:0] dq;

    assign in_rng[p] = {1'b0, addr[p]} < LIMIT;
    assign idx[p]    = addr[p][IW-1:0];
    assign wr[p]     = rstn & req[p] & we[p] & in_rng[p];
    assign rd[p]     = req[p] & ~we[p];

    // Forward the other port's enabled bytes when RDW_MODE asks for new data
    always_ff @(posedge clk) begin
      if (!rstn) begin
        v1 <= 1'b0;
        e1 <= 1'b0;
        d1 <= '0;
      end else begin
        v1 <= rd[p];
        e1 <= req[p] & ~in_rng[p];
        for (int i = 0; i < BE_W; i++) begin
          if (!(rd[p] && in_rng[p]))
            d1[8*i +: 8] <= 8'h00;
          else if (RDW_MODE != 0 && wr[O] && same && be[O][i])
            d1[8*i +: 8] <= wdata[O][8*i +: 8];
          else
            d1[8*i +: 8] <= mem[idx[p]][8*i +: 8];
        end
      end
    end

    if (RD_LATENCY == 2) begin : g_l2
      always_ff @(posedge clk) begin
        if (!rstn) begin
          vq <= 1'b0;
          eq <= 1'b0;
          dq <= '0;
        end else begin
          vq <= v1;
          eq <= e1;
          dq <= d1;
        end
      end
    end else begin : g_l1
      assign vq = v1;
      assign eq = e1;
      assign dq = d1;
    end

    assign rvalid[p] = rstn & vq;
    assign err[p]    = rstn & eq;
    assign rdata[p]  = rvalid[p] ? dq : '0;
  end

endmodule

// File: tb/tb_master_memory_dp_bram.sv
// Bench: two configurations side by side, driven identically, checked
// against a word-level memory model with a per-port response schedule.
module tb_master_memory_dp_bram;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } preq_t;

  typedef struct {
    int          due;
    logic        err;
    logic        v;
    logic [31:0] d;
  } rsp_t;

  localparam int LAT [2] = '{1, 2};
  localparam int SZ  [2] = '{4096, 3000};
  localparam int RDW [2] = '{0, 1};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [11:0] a_addr = '0;
  logic [3:0]  a_be = '0;
  logic [31:0] a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [11:0] b_addr = '0;
  logic [3:0]  b_be = '0;
  logic [31:0] b_wdata = '0;

  logic [31:0] ard [2];
  logic [31:0] brd [2];
  logic        arv [2];
  logic        brv [2];
  logic        aer [2];
  logic        ber [2];
  logic [15:0] cnt [2];

  logic [31:0] mem_m [2][4096];
  logic [15:0] mcnt [2];
  rsp_t        rq [4][$];

  logic        hv [2][2][256];
  logic        he [2][2][256];
  logic [31:0] hd [2][2][256];
  logic [15:0] hc [2][256];

  logic [11:0] pool [16];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  master_memory_dp_bram #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_SIZE(4096),
    .RD_LATENCY(1), .RDW_MODE(0)
  ) u0 (
    .clk(clk), .rstn(rstn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_be(a_be), .a_wdata(a_wdata),
    .a_rdata(ard[0]), .a_rvalid(arv[0]), .a_err(aer[0]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_be(b_be), .b_wdata(b_wdata),
    .b_rdata(brd[0]), .b_rvalid(brv[0]), .b_err(ber[0]),
    .coll_cnt(cnt[0])
  );

  master_memory_dp_bram #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_SIZE(3000),
    .RD_LATENCY(2), .RDW_MODE(1)
  ) u1 (
    .clk(clk), .rstn(rstn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_be(a_be), .a_wdata(a_wdata),
    .a_rdata(ard[1]), .a_rvalid(arv[1]), .a_err(aer[1]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_be(b_be), .b_wdata(b_wdata),
    .b_rdata(brd[1]), .b_rvalid(brv[1]), .b_err(ber[1]),
    .coll_cnt(cnt[1])
  );

  function automatic preq_t idle();
    preq_t r = '0;
    return r;
  endfunction

  function automatic preq_t rd(input logic [11:0] a);
    preq_t r = '0;
    r.req = 1'b1;
    r.addr = a;
    return r;
  endfunction

  function automatic preq_t wr(input logic [11:0] a,
                               input logic [31:0] d,
                               input logic [3:0] be);
    preq_t r = '0;
    r.req = 1'b1;
    r.we = 1'b1;
    r.addr = a;
    r.be = be;
    r.wdata = d;
    return r;
  endfunction

  // One clock: apply requests, advance the model, record outputs.
  task automatic drive(input preq_t pa, input preq_t pb);
    logic ain, bin;
    logic [31:0] oa, ob, na, nb;
    rsp_t r;
    int i;
    a_req = pa.req; a_we = pa.we; a_addr = pa.addr;
    a_be = pa.be; a_wdata = pa.wdata;
    b_req = pb.req; b_we = pb.we; b_addr = pb.addr;
    b_be = pb.be; b_wdata = pb.wdata;
    for (int k = 0; k < 2; k++) begin
      ain = int'(pa.addr) < SZ[k];
      bin = int'(pb.addr) < SZ[k];
      oa = ain ? mem_m[k][pa.addr] : '0;
      ob = bin ? mem_m[k][pb.addr] : '0;
      if (rstn) begin
        for (int j = 0; j < 4; j++) begin
          if (pb.req && pb.we && bin && pb.be[j])
            mem_m[k][pb.addr][8*j +: 8] = pb.wdata[8*j +: 8];
        end
        for (int j = 0; j < 4; j++) begin
          if (pa.req && pa.we && ain && pa.be[j])
            mem_m[k][pa.addr][8*j +: 8] = pa.wdata[8*j +: 8];
        end
      end
      na = ain ? mem_m[k][pa.addr] : '0;
      nb = bin ? mem_m[k][pb.addr] : '0;
      r.due = cyc + LAT[k];
      if (!rstn) begin
        rq[2*k].delete();
        rq[2*k+1].delete();
        mcnt[k] = '0;
      end else begin
        if (pa.req && (!ain || !pa.we)) begin
          r.err = !ain;
          r.v = !pa.we;
          r.d = (!ain || pa.we) ? 32'h0 : (RDW[k] != 0 ? na : oa);
          rq[2*k].push_back(r);
        end
        if (pb.req && (!bin || !pb.we)) begin
          r.err = !bin;
          r.v = !pb.we;
          r.d = (!bin || pb.we) ? 32'h0 : (RDW[k] != 0 ? nb : ob);
          rq[2*k+1].push_back(r);
        end
        if (pa.req && pb.req && ain && bin && pa.addr == pb.addr
            && mcnt[k] != 16'hFFFF)
          mcnt[k] = mcnt[k] + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    i = cyc & 255;
    for (int k = 0; k < 2; k++) begin
      hv[k][0][i] = arv[k]; he[k][0][i] = aer[k]; hd[k][0][i] = ard[k];
      hv[k][1][i] = brv[k]; he[k][1][i] = ber[k]; hd[k][1][i] = brd[k];
      hc[k][i] = cnt[k];
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(rd(12'h005), rd(12'h005));
    drive(wr(12'h003, 32'h1, 4'hF), rd(12'h003));
    drive(idle(), idle());
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({arv[k], aer[k], brv[k], ber[k]} !== 4'b0
          || ard[k] !== 32'h0 || brd[k] !== 32'h0) begin
        bad++;
        $display("FAIL reset_out k%0d: got v=%b%b e=%b%b d=%h/%h want all 0",
                 k, arv[k], brv[k], aer[k], ber[k], ard[k], brd[k]);
      end
      total++;
      if (cnt[k] !== 16'h0) begin
        bad++;
        $display("FAIL reset_cnt k%0d: got %h want 0", k, cnt[k]);
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++)
      drive(wr(pool[i], $urandom, 4'hF), idle());
    drive(idle(), idle());
    drive(idle(), idle());
  endtask

  task automatic test_byte_lanes();
    int c, t;
    drive(wr(12'h010, 32'hDEADBEEF, 4'hF), idle());
    c = cyc + 1;
    drive(idle(), rd(12'h010));
    drive(idle(), idle());
    drive(idle(), idle());
    for (int k = 0; k < 2; k++) begin
      t = c + LAT[k] - 1;
      total++;
      if (hv[k][1][(t-1) & 255] !== 1'b0 || hv[k][1][(t+1) & 255] !== 1'b0) begin
        bad++;
        $display("FAIL lat_pulse k%0d: got pre=%b post=%b want 0 0", k,
                 hv[k][1][(t-1) & 255], hv[k][1][(t+1) & 255]);
      end
      total++;
      if (hv[k][1][t & 255] !== 1'b1 || he[k][1][t & 255] !== 1'b0
          || hd[k][1][t & 255] !== 32'hDEADBEEF) begin
        bad++;
        $display("FAIL full_word k%0d: got v=%b e=%b d=%h want v=1 e=0 d=deadbeef",
                 k, hv[k][1][t & 255], he[k][1][t & 255], hd[k][1][t & 255]);
      end
    end
    drive(wr(12'h011, 32'h11223344, 4'hF), idle());
    drive(wr(12'h011, 32'hAABBCCDD, 4'b0101), idle());
    c = cyc + 1;
    drive(rd(12'h011), idle());
    drive(idle(), idle());
    drive(idle(), idle());
    for (int k = 0; k < 2; k++) begin
      t = c + LAT[k] - 1;
      total++;
      if (hv[k][0][t & 255] !== 1'b1 || hd[k][0][t & 255] !== 32'h11BB33DD) begin
        bad++;
        $display("FAIL byte_en k%0d: got v=%b d=%h want v=1 d=11bb33dd",
                 k, hv[k][0][t & 255], hd[k][0][t & 255]);
      end
    end
  endtask

  task automatic test_collision();
    int c, t;
    logic [31:0] exp_d;
    drive(wr(12'h020, 32'h00000078, 4'hF), idle());
    c = cyc + 1;
    drive(wr(12'h020, 32'hFFFF0000, 4'b1100),
          wr(12'h020, 32'h12345678, 4'b0110));
    for (int k = 0; k < 2; k++) begin
      total++;
      if (hc[k][c & 255] !== 16'd1) begin
        bad++;
        $display("FAIL coll_cnt1 k%0d: got %0d want 1", k, hc[k][c & 255]);
      end
    end
    c = cyc + 1;
    drive(idle(), rd(12'h020));
    drive(idle(), idle());
    drive(idle(), idle());
    for (int k = 0; k < 2; k++) begin
      t = c + LAT[k] - 1;
      total++;
      if (hv[k][1][t & 255] !== 1'b1 || hd[k][1][t & 255] !== 32'hFFFF5678) begin
        bad++;
        $display("FAIL ww_merge k%0d: got v=%b d=%h want v=1 d=ffff5678",
                 k, hv[k][1][t & 255], hd[k][1][t & 255]);
      end
    end
    drive(wr(12'h030, 32'h1, 4'hF), idle());
    c = cyc + 1;
    drive(wr(12'h030, 32'h2, 4'hF), rd(12'h030));
    drive(idle(), idle());
    drive(idle(), idle());
    for (int k = 0; k < 2; k++) begin
      t = c + LAT[k] - 1;
      exp_d = (RDW[k] != 0) ? 32'h2 : 32'h1;
      total++;
      if (hv[k][1][t & 255] !== 1'b1 || hd[k][1][t & 255] !== exp_d) begin
        bad++;
        $display("FAIL rdw_full k%0d: got v=%b d=%h want v=1 d=%h",
                 k, hv[k][1][t & 255], hd[k][1][t & 255], exp_d);
      end
      total++;
      if (hc[k][c & 255] !== 16'd2) begin
        bad++;
        $display("FAIL coll_cnt2 k%0d: got %0d want 2", k, hc[k][c & 255]);
      end
    end
    c = cyc + 1;
    drive(wr(12'h030, 32'hAABBCCDD, 4'b0011), rd(12'h030));
    drive(idle(), idle());
    drive(idle(), idle());
    for (int k = 0; k < 2; k++) begin
      t = c + LAT[k] - 1;
      exp_d = (RDW[k] != 0) ? 32'h0000CCDD : 32'h00000002;
      total++;
      if (hv[k][1][t & 255] !== 1'b1 || hd[k][1][t & 255] !== exp_d) begin
        bad++;
        $display("FAIL rdw_part k%0d: got v=%b d=%h want v=1 d=%h",
                 k, hv[k][1][t & 255], hd[k][1][t & 255], exp_d);
      end
    end
  endtask

  task automatic test_range();
    int c, t;
    logic oor;
    logic [31:0] exp_d;
    c = cyc + 1;
    exp_d = mem_m[0][12'hBB8];
    drive(rd(12'hBB8), idle());
    drive(idle(), idle());
    drive(idle(), idle());
    for (int k = 0; k < 2; k++) begin
      t = c + LAT[k] - 1;
      oor = (k == 1);
      total++;
      if (hv[k][0][t & 255] !== 1'b1 || he[k][0][t & 255] !== oor
          || hd[k][0][t & 255] !== (oor ? 32'h0 : exp_d)
          || he[k][0][(t-1) & 255] !== 1'b0) begin
        bad++;
        $display("FAIL range_rd k%0d: got v=%b e=%b d=%h pre_e=%b want v=1 e=%b d=%h pre_e=0",
                 k, hv[k][0][t & 255], he[k][0][t & 255], hd[k][0][t & 255],
                 he[k][0][(t-1) & 255], oor, oor ? 32'h0 : exp_d);
      end
    end
    c = cyc + 1;
    drive(wr(12'hBB8, 32'h5A5A5A5A, 4'hF), wr(12'hBB7, 32'h0BB70BB7, 4'hF));
    drive(idle(), idle());
    drive(idle(), idle());
    for (int k = 0; k < 2; k++) begin
      t = c + LAT[k] - 1;
      total++;
      if (hv[k][0][t & 255] !== 1'b0 || he[k][0][t & 255] !== (k == 1)
          || he[k][1][t & 255] !== 1'b0) begin
        bad++;
        $display("FAIL range_wr k%0d: got v=%b ea=%b eb=%b want v=0 ea=%b eb=0",
                 k, hv[k][0][t & 255], he[k][0][t & 255], he[k][1][t & 255], k == 1);
      end
    end
    c = cyc + 1;
    drive(rd(12'hBB7), rd(12'hBB8));
    drive(idle(), idle());
    drive(idle(), idle());
    for (int k = 0; k < 2; k++) begin
      t = c + LAT[k] - 1;
      total++;
      if (hv[k][0][t & 255] !== 1'b1 || he[k][0][t & 255] !== 1'b0
          || hd[k][0][t & 255] !== 32'h0BB70BB7) begin
        bad++;
        $display("FAIL last_word k%0d: got v=%b e=%b d=%h want v=1 e=0 d=0bb70bb7",
                 k, hv[k][0][t & 255], he[k][0][t & 255], hd[k][0][t & 255]);
      end
      exp_d = (k == 1) ? 32'h0 : 32'h5A5A5A5A;
      total++;
      if (hv[k][1][t & 255] !== 1'b1 || he[k][1][t & 255] !== (k == 1)
          || hd[k][1][t & 255] !== exp_d) begin
        bad++;
        $display("FAIL range_rb k%0d: got v=%b e=%b d=%h want v=1 e=%b d=%h",
                 k, hv[k][1][t & 255], he[k][1][t & 255], hd[k][1][t & 255],
                 k == 1, exp_d);
      end
    end
  endtask

  task automatic test_reset_squash();
    int c1, c2, c3, c4, c5, t, l;
    logic ev;
    c1 = cyc + 1;
    drive(rd(12'h005), rd(12'h005));
    c2 = cyc + 1;
    drive(rd(12'h006), rd(12'h006));
    rstn = 1'b0;
    c3 = cyc + 1;
    drive(rd(12'h007), wr(12'h007, 32'hBAD0BAD0, 4'hF));
    rstn = 1'b1;
    c4 = cyc + 1;
    drive(rd(12'h008), rd(12'h008));
    drive(idle(), idle());
    drive(idle(), idle());
    for (int k = 0; k < 2; k++) begin
      l = LAT[k] - 1;
      for (t = c1; t <= c4 + 1; t++) begin
        ev = (t == c1 + l) || (t == c2 + l && t < c3) || (t == c4 + l);
        total++;
        if (hv[k][0][t & 255] !== ev || hv[k][1][t & 255] !== ev) begin
          bad++;
          $display("FAIL squash k%0d t%0d: got va=%b vb=%b want %b",
                   k, t - c1, hv[k][0][t & 255], hv[k][1][t & 255], ev);
        end
      end
      t = c4 + l;
      total++;
      if (hd[k][0][t & 255] !== mem_m[k][8] || hd[k][1][t & 255] !== mem_m[k][8]) begin
        bad++;
        $display("FAIL post_rst_data k%0d: got %h/%h want %h",
                 k, hd[k][0][t & 255], hd[k][1][t & 255], mem_m[k][8]);
      end
      total++;
      if (hc[k][c3 & 255] !== 16'd0 || hc[k][c4 & 255] !== 16'd1) begin
        bad++;
        $display("FAIL rst_cnt k%0d: got %0d,%0d want 0,1",
                 k, hc[k][c3 & 255], hc[k][c4 & 255]);
      end
    end
    c5 = cyc + 1;
    drive(rd(12'h007), idle());
    drive(idle(), idle());
    drive(idle(), idle());
    for (int k = 0; k < 2; k++) begin
      t = c5 + LAT[k] - 1;
      total++;
      if (hv[k][0][t & 255] !== 1'b1 || hd[k][0][t & 255] !== mem_m[k][7]) begin
        bad++;
        $display("FAIL rst_wr_block k%0d: got v=%b d=%h want v=1 d=%h",
                 k, hv[k][0][t & 255], hd[k][0][t & 255], mem_m[k][7]);
      end
    end
  endtask

  task automatic test_back_to_back();
    preq_t pa, pb;
    rsp_t r;
    int q;
    logic ev, ee, av, ae;
    logic [31:0] ed, ad;
    for (int n = 0; n < 600; n++) begin
      pa = wr(pool[$urandom_range(0, 15)], $urandom, 4'($urandom_range(0, 15)));
      pa.req = ($urandom_range(0, 3) != 0);
      pa.we = 1'($urandom_range(0, 1));
      pb = wr(pool[$urandom_range(0, 15)], $urandom, 4'($urandom_range(0, 15)));
      pb.req = ($urandom_range(0, 3) != 0);
      pb.we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        pb.addr = pa.addr;
      drive(pa, pb);
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          q = 2 * k + p;
          while (rq[q].size() > 0 && rq[q][0].due < cyc)
            void'(rq[q].pop_front());
          ev = 1'b0; ee = 1'b0; ed = 32'h0;
          if (rq[q].size() > 0 && rq[q][0].due == cyc) begin
            r = rq[q].pop_front();
            ev = r.v; ee = r.err; ed = r.d;
          end
          av = p ? brv[k] : arv[k];
          ae = p ? ber[k] : aer[k];
          ad = p ? brd[k] : ard[k];
          total++;
          if (av !== ev || ae !== ee || ad !== ed) begin
            bad++;
            $display("FAIL rand k%0d p%0d n%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                     k, p, n, av, ae, ad, ev, ee, ed);
          end
        end
        total++;
        if (cnt[k] !== mcnt[k]) begin
          bad++;
          $display("FAIL rand_cnt k%0d n%0d: got %0d want %0d", k, n, cnt[k], mcnt[k]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 10; i++)
      pool[i] = 12'(i);
    pool[10] = 12'h010;
    pool[11] = 12'h011;
    pool[12] = 12'h020;
    pool[13] = 12'h030;
    pool[14] = 12'hBB8;
    pool[15] = 12'hFFF;
    mcnt[0] = '0;
    mcnt[1] = '0;
    test_reset();
    test_fill();
    test_byte_lanes();
    test_collision();
    test_range();
    test_reset_squash();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
